// File: rtl/memory_stream_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | memory_stream_pkg : shared encodings for memory_stream_ctrl          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package memory_stream_pkg;

  localparam int M_DEFAULT = 164;
  localparam int N_DEFAULT = 8;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_OUT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/memory_stream_ctrl_if.sv
// +----------------------------------------------------------------------+
// | memory_stream_ctrl_if : command, stream and memory-port bundle       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface memory_stream_ctrl_if #(
  parameter int N  = 8,
  parameter int AW = 8
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;

  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_last;

  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_data_in;
  logic          mem_write_enable;
  logic [N-1:0]  mem_data_out;

  logic          busy;
  logic          done;
  logic          err;

  // master = the sequencer, slave = front-end plus memory
  modport master (
    input  cmd_valid, cmd_op, cmd_base, cmd_len,
    input  in_valid, in_data, out_ready, mem_data_out,
    output cmd_ready, in_ready, out_valid, out_data, out_last,
    output mem_addr, mem_data_in, mem_write_enable,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_base, cmd_len,
    output in_valid, in_data, out_ready, mem_data_out,
    input  cmd_ready, in_ready, out_valid, out_data, out_last,
    input  mem_addr, mem_data_in, mem_write_enable,
    input  busy, done, err
  );

endinterface

`default_nettype wire

// File: rtl/memory_stream_ctrl.sv
// +----------------------------------------------------------------------+
// | memory_stream_ctrl : LOAD/DUMP sequencer for the byte memory port    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module memory_stream_ctrl
  import memory_stream_pkg::*;
#(
  parameter int M  = M_DEFAULT,
  parameter int N  = N_DEFAULT,
  parameter int AW = $clog2(M)
) (
  input  logic clk,
  input  logic reset,
  memory_stream_ctrl_if.master bus
);

  localparam logic [AW+1:0] M_LIMIT = (AW+2)'(M);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   REM_ONE = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [AW+1:0] cmd_end;
  logic          last_word;

  assign cmd_end   = {2'b00, bus.cmd_base} + {1'b0, bus.cmd_len};
  assign last_word = (remaining_q == REM_ONE);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if ((bus.cmd_len == '0) || (cmd_end > M_LIMIT)) begin
            err_d = 1'b1;
          end else begin
            ptr_d       = bus.cmd_base;
            remaining_d = bus.cmd_len;
            case (bus.cmd_op)
              OP_LOAD: state_d = ST_LOAD;
              OP_DUMP: state_d = ST_RD_WAIT;
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end

      ST_LOAD: begin
        if (bus.in_valid) begin
          ptr_d       = ptr_q + PTR_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (last_word) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      // Address was held for a full cycle, so both combinational and
      // registered memory reads are valid at this edge.
      ST_RD_WAIT: begin
        out_data_d = bus.mem_data_out;
        state_d    = ST_RD_OUT;
      end

      ST_RD_OUT: begin
        if (bus.out_ready) begin
          if (last_word) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d       = ptr_q + PTR_ONE;
            remaining_d = remaining_q - REM_ONE;
            state_d     = ST_RD_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Write strobe is combinational on in_valid; masked by reset so an
  // aborting cycle can never commit a word.
  assign bus.cmd_ready        = (state_q == ST_IDLE);
  assign bus.in_ready         = (state_q == ST_LOAD) && reset;
  assign bus.mem_write_enable = (state_q == ST_LOAD) && bus.in_valid && reset;
  assign bus.mem_addr         = ptr_q;
  assign bus.mem_data_in      = (state_q == ST_LOAD) ? bus.in_data : '0;
  assign bus.out_valid        = (state_q == ST_RD_OUT);
  assign bus.out_last         = (state_q == ST_RD_OUT) && last_word;
  assign bus.out_data         = out_data_q;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.done             = done_q;
  assign bus.err              = err_q;

endmodule

`default_nettype wire

// File: doc/memory_stream_ctrl.md
Name: memory_stream_ctrl

Overview:
- Sequencer on the initiator side of the byte memory's write/read port: it drives addr, data_in and write_enable, and reads data_out.
- Takes one command at a time: LOAD (copy a valid/ready byte stream into consecutive addresses) or DUMP (read consecutive addresses and emit them as a valid/ready byte stream).
- Sits between the chip's serial/IO front-end and the weight/config memory; the memory is not instantiated inside this block.

Parameters:
M, 164, number of memory words
N, 8, word width in bits
AW, $clog2(M), address width

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
cmd_op  in  1  0=LOAD, 1=DUMP
cmd_base  in  AW  first address
cmd_len  in  AW+1  word count; legal range 1..M
in_valid  in  1  LOAD data valid
in_ready  out  1  LOAD data accepted
in_data  in  N  LOAD data
out_valid  out  1  DUMP data valid
out_ready  in  1  DUMP sink ready
out_data  out  N  DUMP data
out_last  out  1  marks the final DUMP word
mem_addr  out  AW  to memory addr
mem_data_in  out  N  to memory data_in
mem_write_enable  out  1  to memory write_enable
mem_data_out  in  N  from memory data_out
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on command completion
err  out  1  one-cycle pulse on command rejection

Behaviour:
- States: IDLE, LOAD, RD_WAIT, RD_OUT.
- Reset (reset=0 at a clock edge): state=IDLE, ptr=0, remaining=0, out_data=0, done=0, err=0. After reset: cmd_ready=1, in_ready=0, out_valid=0, out_last=0, mem_write_enable=0, mem_addr=0, mem_data_in=0, busy=0.
- Reset mid-command aborts immediately. There is no partial-completion pulse, and no write is issued in the reset cycle.
- IDLE: cmd_ready=1, no other activity.
  - On cmd_valid, compute base+len at AW+2 bits.
  - If len==0 or base+len>M: pulse err the next cycle, stay IDLE, no memory access.
  - Otherwise latch ptr=base and remaining=len, then go to LOAD (op=0) or RD_WAIT (op=1).
- cmd_ready=0 in every state except IDLE. Commands offered while busy are not accepted.
- mem_addr = ptr in all states. mem_data_in = in_data in LOAD, else 0.
- LOAD:
  - in_ready=1. mem_write_enable = in_valid, combinational, so the memory captures in_data at ptr on that edge.
  - Each accepted word: ptr+1, remaining-1.
  - On the word where remaining==1: return to IDLE and pulse done the next cycle.
  - in_valid gaps insert idle cycles with no write.
- RD_WAIT: one cycle with mem_addr=ptr held. At the end of the cycle, out_data <= mem_data_out and go to RD_OUT. This is correct for both combinational and 1-cycle-registered memory reads.
- RD_OUT:
  - out_valid=1. out_last=1 when remaining==1.
  - out_data and out_last hold stable while out_ready=0.
  - On handshake: if last, go to IDLE and pulse done next cycle; else ptr+1, remaining-1, go to RD_WAIT.
  - Peak throughput is 1 word per 2 cycles.
- mem_write_enable is never high outside LOAD. DUMP never writes.
- Address range: no wrap-around is possible because the range is checked at accept. The highest address touched is base+len-1, which is at most M-1.
- done and err are registered pulses, exactly one cycle wide, never both high.

Decomposition:
- Package memory_stream_pkg holds:
  - state encoding constants ST_IDLE, ST_LOAD, ST_RD_WAIT, ST_RD_OUT;
  - OP_LOAD=0, OP_DUMP=1;
  - defaults M=164, N=8.
- No sub-module: one FSM, one pointer/counter pair, one output register.
- The bench instantiates the existing memory module alongside this block.

Test Plan:
1. Reset, then LOAD base=0 len=5, in_valid held high, data A0..A4 -> five write_enable cycles at addr 0..4; done pulses the cycle after A4; memory all_data_out low 40 bits = A4A3A2A1A0.
2. DUMP base=0 len=5, out_ready=1 -> out_data A0,A1,A2,A3,A4, 2 cycles apart; out_last only on A4; done once; write_enable stays 0.
3. LOAD base=11 len=5 E0..E4 with in_valid low every other cycle, then DUMP base=11 with out_ready toggling -> E0..E4 in order; out_data stable during stalls; locations 0..4 still hold A0..A4.
4. Range and length checks: base=160 len=5 -> err, no write; len=0 -> err; base=159 len=5 -> accepted, last write at addr 163, done.
5. Busy and reset abort: issue DUMP base=0 len=5 and hold cmd_valid high with a LOAD command while busy -> cmd_ready=0, second command not taken. Then drive reset=0 after two words -> next cycle busy=0, out_valid=0, no done. A fresh DUMP then returns A0..A4.
